// File: rtl/tlb_responder.sv
// Responder end of the translation-request protocol: one request at a time,
// looked up in a small fully-associative TLB that fills from the page-table walker.
module tlb_responder #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 52,
    parameter int PPN_W   = 44
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VPN_W-1:0] req_vpn,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [PPN_W-1:0] resp_ppn,
    output logic             resp_fault,
    output logic             ptw_req_valid,
    input  logic             ptw_req_ready,
    output logic [VPN_W-1:0] ptw_req_vpn,
    input  logic             ptw_resp_valid,
    input  logic [PPN_W-1:0] ptw_resp_ppn,
    input  logic             ptw_resp_fault,
    input  logic             flush
);
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [2:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT, RESP} state_t;

    state_t             state_q;
    logic [VPN_W-1:0]   vpn_q;
    logic               kill_q;
    logic               resp_valid_q;
    logic               resp_fault_q;
    logic [PPN_W-1:0]   resp_ppn_q;
    logic               ptw_req_valid_q;
    logic [VPN_W-1:0]   ptw_req_vpn_q;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [VPN_W-1:0]   tag_q  [ENTRIES];
    logic [PPN_W-1:0]   data_q [ENTRIES];

    logic [ENTRIES-1:0] hit_vec;
    logic               hit;
    logic [PPN_W-1:0]   hit_ppn;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim;
    logic               fill_en;

    assign req_ready     = (state_q == IDLE) && !flush;
    assign resp_valid    = resp_valid_q;
    assign resp_ppn      = resp_ppn_q;
    assign resp_fault    = resp_fault_q;
    assign ptw_req_valid = ptw_req_valid_q;
    assign ptw_req_vpn   = ptw_req_vpn_q;

    // At most one entry can match, so OR-ing the matching PPNs is a plain mux.
    always_comb begin
        hit_vec = '0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            hit_vec[i] = valid_q[i] && (tag_q[i] == vpn_q);
            if (hit_vec[i]) begin
                hit_ppn = hit_ppn | data_q[i];
            end
        end
        hit = |hit_vec;
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        victim = free_found ? free_idx : ptr_q;
    end

    assign fill_en = (state_q == WALK_WAIT) && ptw_resp_valid && !ptw_resp_fault
                     && !kill_q && !flush;

    // Flush overrides a coincident fill, leaving the victim invalid.
    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (fill_en) begin
            valid_d[victim] = 1'b1;
            if (!free_found) begin
                ptr_d = ptr_q + IDX_W'(1);
            end
        end
        if (flush) begin
            valid_d = '0;
            ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            if (fill_en) begin
                tag_q[victim]  <= vpn_q;
                data_q[victim] <= ptw_resp_ppn;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            vpn_q           <= '0;
            kill_q          <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_fault_q    <= 1'b0;
            resp_ppn_q      <= '0;
            ptw_req_valid_q <= 1'b0;
            ptw_req_vpn_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        vpn_q   <= req_vpn;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit && !flush) begin
                        resp_ppn_q   <= hit_ppn;
                        resp_fault_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        ptw_req_valid_q <= 1'b1;
                        ptw_req_vpn_q   <= vpn_q;
                        state_q         <= WALK_REQ;
                    end
                end
                WALK_REQ: begin
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (ptw_req_ready) begin
                        ptw_req_valid_q <= 1'b0;
                        state_q         <= WALK_WAIT;
                    end
                end
                WALK_WAIT: begin
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (ptw_resp_valid) begin
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= ptw_resp_fault;
                        resp_ppn_q   <= ptw_resp_fault ? '0 : ptw_resp_ppn;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        kill_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
                     (state_q == LOOKUP) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_tlb_responder.sv
// Self-checking bench for tlb_responder: directed scenarios plus randomized
// traffic, checked against an entry-array model of the TLB and its replacement rules.
module tb_tlb_responder;
    localparam int ENTRIES = 8;
    localparam int VPN_W   = 52;
    localparam int PPN_W   = 44;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [VPN_W-1:0] req_vpn;
    logic             resp_valid;
    logic             resp_ready;
    logic [PPN_W-1:0] resp_ppn;
    logic             resp_fault;
    logic             ptw_req_valid;
    logic             ptw_req_ready;
    logic [VPN_W-1:0] ptw_req_vpn;
    logic             ptw_resp_valid;
    logic [PPN_W-1:0] ptw_resp_ppn;
    logic             ptw_resp_fault;
    logic             flush;

    int total  = 0;
    int passed = 0;

    // Model of the TLB contents
    bit               mValid [ENTRIES];
    logic [VPN_W-1:0] mVpn   [ENTRIES];
    logic [PPN_W-1:0] mPpn   [ENTRIES];
    int               mPtr;

    // Expectations consumed by the per-cycle monitor
    logic [VPN_W-1:0] monVpn   = '0;
    logic [PPN_W-1:0] monPpn   = '0;
    bit               monFault = 1'b0;

    tlb_responder #(.ENTRIES(ENTRIES), .VPN_W(VPN_W), .PPN_W(PPN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_ppn(resp_ppn), .resp_fault(resp_fault),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_req_vpn(ptw_req_vpn),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
        .ptw_resp_fault(ptw_resp_fault),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [PPN_W-1:0] walkPpn(input logic [VPN_W-1:0] vpn);
        if (vpn == 52'h1234) return 44'hABC;
        return vpn[PPN_W-1:0] ^ 44'hF0F0;
    endfunction

    function automatic void modelFlush();
        for (int i = 0; i < ENTRIES; i++) mValid[i] = 1'b0;
        mPtr = 0;
    endfunction

    function automatic void modelLookup(input logic [VPN_W-1:0] vpn, output bit hit,
                                        output logic [PPN_W-1:0] ppn);
        hit = 1'b0;
        ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (mValid[i] && mVpn[i] == vpn) begin
                hit = 1'b1;
                ppn = mPpn[i];
            end
        end
    endfunction

    function automatic void modelFill(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] ppn);
        int v;
        v = -1;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!mValid[i] && v < 0) v = i;
        end
        if (v < 0) begin
            v = mPtr;
            mPtr = (mPtr + 1) % ENTRIES;
        end
        mValid[v] = 1'b1;
        mVpn[v]   = vpn;
        mPpn[v]   = ppn;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (resp_valid) begin
                checkOutput("mon_resp_ppn", 64'(resp_ppn), 64'(monPpn));
                checkOutput("mon_resp_fault", 64'(resp_fault), 64'(monFault));
            end
            if (ptw_req_valid) begin
                checkOutput("mon_ptw_vpn", 64'(ptw_req_vpn), 64'(monVpn));
            end
        end
    end

    // flushMode: 0 none, 1 during lookup, 2 during walk wait, 3 on the fill edge, 4 during response
    task automatic applyStimulus(input logic [VPN_W-1:0] vpn, input bit fault, input int stall,
                                 input int delay, input int hold, input int flushMode,
                                 output bit walked, output logic [PPN_W-1:0] gotPpn,
                                 output bit gotFault);
        bit               expHit;
        bit               kill;
        logic [PPN_W-1:0] expPpn;
        int               guard;
        kill = 1'b0;
        modelLookup(vpn, expHit, expPpn);
        @(negedge clk);
        monVpn   = vpn;
        monPpn   = expPpn;
        monFault = 1'b0;
        req_valid = 1'b1;
        req_vpn   = vpn;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("req_accept_timeout", 64'(req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("lookup_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("lookup_ptw_valid", 64'(ptw_req_valid), 64'(0));
        if (flushMode == 1) begin
            flush = 1'b1;
            modelFlush();
            expHit = 1'b0;
        end
        @(negedge clk);
        walked = ptw_req_valid;
        checkOutput("path_ptw_valid", 64'(ptw_req_valid), 64'(!expHit));
        checkOutput("path_resp_valid", 64'(resp_valid), 64'(expHit));
        flush = 1'b0;
        if (!expHit) begin
            checkOutput("ptw_vpn", 64'(ptw_req_vpn), 64'(vpn));
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                checkOutput("ptw_hold_valid", 64'(ptw_req_valid), 64'(1));
                checkOutput("ptw_hold_vpn", 64'(ptw_req_vpn), 64'(vpn));
            end
            ptw_req_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ptw_req_ready = 1'b0;
            checkOutput("walk_wait_ptw_valid", 64'(ptw_req_valid), 64'(0));
            if (flushMode == 2) begin
                flush = 1'b1;
                modelFlush();
                kill = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
            for (int i = 0; i < delay; i++) begin
                checkOutput("walk_wait_resp_valid", 64'(resp_valid), 64'(0));
                @(negedge clk);
            end
            expPpn   = fault ? '0 : walkPpn(vpn);
            monPpn   = expPpn;
            monFault = fault;
            ptw_resp_valid = 1'b1;
            ptw_resp_ppn   = walkPpn(vpn);
            ptw_resp_fault = fault;
            if (flushMode == 3) begin
                flush = 1'b1;
                modelFlush();
                kill = 1'b1;
            end
            @(negedge clk);
            ptw_resp_valid = 1'b0;
            ptw_resp_fault = 1'b0;
            flush = 1'b0;
            if (!fault && !kill) modelFill(vpn, walkPpn(vpn));
        end
        checkOutput("resp_valid", 64'(resp_valid), 64'(1));
        checkOutput("resp_ppn", 64'(resp_ppn), 64'(expPpn));
        checkOutput("resp_fault", 64'(resp_fault), 64'(expHit ? 1'b0 : fault));
        gotPpn   = resp_ppn;
        gotFault = resp_fault;
        for (int i = 0; i < hold; i++) begin
            if (flushMode == 4 && i == 0) begin
                flush = 1'b1;
                modelFlush();
            end
            @(negedge clk);
            checkOutput("hold_resp_valid", 64'(resp_valid), 64'(1));
            checkOutput("hold_resp_ppn", 64'(resp_ppn), 64'(expPpn));
            checkOutput("hold_req_ready", 64'(req_ready), 64'(0));
            flush = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("post_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("post_req_ready", 64'(req_ready), 64'(1));
    endtask

    task automatic flushIdle();
        @(negedge clk);
        flush = 1'b1;
        #1 checkOutput("flush_req_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        flush = 1'b0;
        modelFlush();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit               w;
        bit               f;
        logic [PPN_W-1:0] p;
        logic [VPN_W-1:0] v;
        int               mode;
        int               hold;
        int               guard;

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_vpn = '0;
        resp_ready = 1'b0;
        ptw_req_ready = 1'b0;
        ptw_resp_valid = 1'b0;
        ptw_resp_ppn = '0;
        ptw_resp_fault = 1'b0;
        flush = 1'b0;
        modelFlush();
        #12;
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("rst_ptw_valid", 64'(ptw_req_valid), 64'(0));
        checkOutput("rst_resp_ppn", 64'(resp_ppn), 64'(0));
        checkOutput("rst_ptw_vpn", 64'(ptw_req_vpn), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("rst_req_ready", 64'(req_ready), 64'(1));

        // Miss then hit on the same VPN
        applyStimulus(52'h1234, 1'b0, 0, 1, 0, 0, w, p, f);
        checkOutput("t1_walk", 64'(w), 64'(1));
        checkOutput("t1_ppn", 64'(p), 64'h0ABC);
        checkOutput("t1_fault", 64'(f), 64'(0));
        applyStimulus(52'h1234, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t1_hit", 64'(w), 64'(0));
        checkOutput("t1_hit_ppn", 64'(p), 64'h0ABC);

        // Fill all entries, then evict via the replacement pointer
        flushIdle();
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus(52'h10 + VPN_W'(i), 1'b0, 0, 0, 0, 0, w, p, f);
            checkOutput("t2_fill_walk", 64'(w), 64'(1));
        end
        applyStimulus(52'h18, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t2_evict_walk", 64'(w), 64'(1));
        applyStimulus(52'h11, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t2_survivor_hit", 64'(w), 64'(0));
        checkOutput("t2_survivor_ppn", 64'(p), 64'h0F0E1);
        applyStimulus(52'h10, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t2_evicted_walk", 64'(w), 64'(1));

        // Walk fault is reported and not cached
        applyStimulus(52'h55, 1'b1, 0, 2, 0, 0, w, p, f);
        checkOutput("t3_fault", 64'(f), 64'(1));
        checkOutput("t3_fault_ppn", 64'(p), 64'(0));
        applyStimulus(52'h55, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t3_rewalk", 64'(w), 64'(1));
        checkOutput("t3_rewalk_ppn", 64'(p), 64'h0F0A5);

        // Backpressure on both sides
        applyStimulus(52'h66, 1'b0, 3, 2, 5, 0, w, p, f);

        // Flush variants
        applyStimulus(52'h20, 1'b0, 1, 1, 0, 2, w, p, f);
        checkOutput("t5_killed_ppn", 64'(p), 64'h0F0D0);
        applyStimulus(52'h20, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t5_killed_rewalk", 64'(w), 64'(1));
        applyStimulus(52'h20, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t5_cached_hit", 64'(w), 64'(0));
        flushIdle();
        applyStimulus(52'h20, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t5_idle_flush_walk", 64'(w), 64'(1));
        applyStimulus(52'h30, 1'b0, 0, 0, 0, 3, w, p, f);
        applyStimulus(52'h30, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t5_fill_edge_flush_walk", 64'(w), 64'(1));
        applyStimulus(52'h30, 1'b0, 0, 0, 0, 1, w, p, f);
        checkOutput("t5_lookup_flush_walk", 64'(w), 64'(1));
        applyStimulus(52'h30, 1'b0, 0, 0, 2, 4, w, p, f);
        checkOutput("t5_resp_flush_hit", 64'(w), 64'(0));
        applyStimulus(52'h30, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t5_resp_flush_walk", 64'(w), 64'(1));

        // Reset while waiting on the walker
        @(negedge clk);
        monVpn = 52'h777;
        req_valid = 1'b1;
        req_vpn = 52'h777;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("t6_accept_timeout", 64'(req_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        ptw_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ptw_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("t6_ptw_valid", 64'(ptw_req_valid), 64'(0));
        checkOutput("t6_resp_fault", 64'(resp_fault), 64'(0));
        checkOutput("t6_resp_ppn", 64'(resp_ppn), 64'(0));
        checkOutput("t6_ptw_vpn", 64'(ptw_req_vpn), 64'(0));
        modelFlush();
        @(negedge clk);
        rst_n = 1'b1;
        ptw_resp_valid = 1'b1;
        ptw_resp_ppn = 44'h999;
        @(negedge clk);
        ptw_resp_valid = 1'b0;
        checkOutput("t6_stale_resp_valid", 64'(resp_valid), 64'(0));
        checkOutput("t6_stale_ptw_valid", 64'(ptw_req_valid), 64'(0));
        checkOutput("t6_req_ready", 64'(req_ready), 64'(1));
        applyStimulus(52'h777, 1'b0, 0, 0, 0, 0, w, p, f);
        checkOutput("t6_post_reset_walk", 64'(w), 64'(1));

        // Randomized traffic over a VPN pool larger than the TLB
        for (int n = 0; n < 40; n++) begin
            v = 52'h100 + VPN_W'($urandom_range(0, 11));
            mode = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 4)) : 0;
            hold = int'($urandom_range(0, 2));
            if (mode == 4 && hold == 0) hold = 1;
            applyStimulus(v, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 3)), hold, mode, w, p, f);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
